// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution cluster.
//   - alu_op_e    : opcodes carried on command_op
//   - rs_state_e  : reservation-station life cycle
package alu_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpAnd = 2'd2,
        OpXor = 2'd3
    } alu_op_e;

    // FREE -> WAIT/READY on dispatch, WAIT -> READY when both operands are
    // captured, READY -> ISSUED when loaded into the output register,
    // ISSUED -> FREE once the CDB accepts the broadcast.
    typedef enum logic [1:0] {
        StFree   = 2'd0,
        StWait   = 2'd1,
        StReady  = 2'd2,
        StIssued = 2'd3
    } rs_state_e;

endpackage

// File: rtl/alu_execution_cluster_if.sv
// Command, CDB-snoop and CDB-output bundle of the ALU execution cluster.
//   master : frontend / bus side (drives commands, snoop data, CDB grant)
//   slave  : the cluster (returns accept, tag, CDB request/data/tag, busy count)
interface alu_execution_cluster_if #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned CDB_TAG_WIDTH = 4,
    parameter int unsigned RS_COUNT      = 6,
    parameter int unsigned OP_WIDTH      = 2
);
    localparam int unsigned CNT_WIDTH = $clog2(RS_COUNT + 1);

    // Dispatch port
    logic                     command_update_en;
    logic [OP_WIDTH-1:0]      command_op;
    logic [DATA_WIDTH-1:0]    operand_a_data;
    logic [DATA_WIDTH-1:0]    operand_b_data;
    logic                     operand_a_data_is_valid;
    logic                     operand_b_data_is_valid;
    logic                     command_update_accepted;
    logic [CDB_TAG_WIDTH-1:0] command_result_cdb_tag;

    // CDB snoop
    logic                     cdb_in_valid;
    logic [CDB_TAG_WIDTH-1:0] cdb_in_tag;
    logic [DATA_WIDTH-1:0]    cdb_in_data;

    // CDB output
    logic                     cdb_out_request;
    logic [DATA_WIDTH-1:0]    cdb_out_data;
    logic [CDB_TAG_WIDTH-1:0] cdb_out_tag;
    logic                     cdb_out_accepted;

    logic [CNT_WIDTH-1:0]     busy_count;

    modport master (
        output command_update_en, command_op, operand_a_data, operand_b_data,
               operand_a_data_is_valid, operand_b_data_is_valid,
               cdb_in_valid, cdb_in_tag, cdb_in_data, cdb_out_accepted,
        input  command_update_accepted, command_result_cdb_tag,
               cdb_out_request, cdb_out_data, cdb_out_tag, busy_count
    );

    modport slave (
        input  command_update_en, command_op, operand_a_data, operand_b_data,
               operand_a_data_is_valid, operand_b_data_is_valid,
               cdb_in_valid, cdb_in_tag, cdb_in_data, cdb_out_accepted,
        output command_update_accepted, command_result_cdb_tag,
               cdb_out_request, cdb_out_data, cdb_out_tag, busy_count
    );

endinterface

// File: rtl/alu_rs_slot.sv
// One ALU reservation station: holds opcode and two operands, snoops the CDB
// for pending operands (including on the dispatch cycle itself) and presents
// the combinational ALU result.
//   clk, rst_n, flush         : clock, async active-low reset, sync clear
//   dispatch, dispatch_*      : load a new command (only honoured when FREE)
//   cdb_in_*                  : CDB snoop
//   issue                     : READY -> ISSUED (loaded into output register)
//   retire                    : ISSUED -> FREE (broadcast accepted)
//   state, result             : current state and ALU result
module alu_rs_slot
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned CDB_TAG_WIDTH = 4,
    parameter int unsigned OP_WIDTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     dispatch,
    input  logic [OP_WIDTH-1:0]      dispatch_op,
    input  logic [DATA_WIDTH-1:0]    dispatch_a,
    input  logic                     dispatch_a_valid,
    input  logic [DATA_WIDTH-1:0]    dispatch_b,
    input  logic                     dispatch_b_valid,
    input  logic                     cdb_in_valid,
    input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
    input  logic [DATA_WIDTH-1:0]    cdb_in_data,
    input  logic                     issue,
    input  logic                     retire,
    output rs_state_e                state,
    output logic [DATA_WIDTH-1:0]    result
);

    rs_state_e             state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    // Pending operands carry the producer tag in their low bits.
    logic a_hit_disp, b_hit_disp, a_hit_wait, b_hit_wait;
    assign a_hit_disp = !dispatch_a_valid && cdb_in_valid &&
                        (dispatch_a[CDB_TAG_WIDTH-1:0] == cdb_in_tag);
    assign b_hit_disp = !dispatch_b_valid && cdb_in_valid &&
                        (dispatch_b[CDB_TAG_WIDTH-1:0] == cdb_in_tag);
    assign a_hit_wait = !a_valid_q && cdb_in_valid && (a_q[CDB_TAG_WIDTH-1:0] == cdb_in_tag);
    assign b_hit_wait = !b_valid_q && cdb_in_valid && (b_q[CDB_TAG_WIDTH-1:0] == cdb_in_tag);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        if (flush) begin
            state_d = StFree;
        end else begin
            case (state_q)
                StFree: begin
                    if (dispatch) begin
                        op_d      = dispatch_op;
                        a_d       = a_hit_disp ? cdb_in_data : dispatch_a;
                        b_d       = b_hit_disp ? cdb_in_data : dispatch_b;
                        a_valid_d = dispatch_a_valid || a_hit_disp;
                        b_valid_d = dispatch_b_valid || b_hit_disp;
                        state_d   = (a_valid_d && b_valid_d) ? StReady : StWait;
                    end
                end
                StWait: begin
                    if (a_hit_wait) begin
                        a_d       = cdb_in_data;
                        a_valid_d = 1'b1;
                    end
                    if (b_hit_wait) begin
                        b_d       = cdb_in_data;
                        b_valid_d = 1'b1;
                    end
                    if (a_valid_d && b_valid_d) state_d = StReady;
                end
                StReady: begin
                    if (issue) state_d = StIssued;
                end
                StIssued: begin
                    if (retire) state_d = StFree;
                end
                default: state_d = StFree;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFree;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    always_comb begin
        result = '0;
        case (alu_op_e'(op_q[1:0]))
            OpAdd:   result = a_q + b_q;
            OpSub:   result = a_q - b_q;
            OpAnd:   result = a_q & b_q;
            OpXor:   result = a_q ^ b_q;
            default: result = '0;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/alu_execution_cluster.sv
// Pool of RS_COUNT ALU reservation stations behind one dispatch port, with a
// round-robin issue pointer feeding a single registered CDB output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all stations, output register and rr_ptr
//   bus        : slave side of alu_execution_cluster_if (dispatch, CDB snoop,
//                CDB output, busy_count)
module alu_execution_cluster
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned CDB_TAG_WIDTH  = 4,
    parameter int unsigned RS_COUNT       = 6,
    parameter int unsigned CDB_TAG_OFFSET = 0,
    parameter int unsigned OP_WIDTH       = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   flush,
    alu_execution_cluster_if.slave bus
);

    localparam int unsigned IDX_W = (RS_COUNT > 1) ? $clog2(RS_COUNT) : 1;
    localparam int unsigned CNT_W = $clog2(RS_COUNT + 1);

    rs_state_e             state [RS_COUNT];
    logic [DATA_WIDTH-1:0] result [RS_COUNT];
    logic [RS_COUNT-1:0]   free, ready;

    logic                  any_free, accept_cmd;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  hit, load, out_fire;
    logic [IDX_W-1:0]      hit_idx;

    logic                     out_valid_q;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic [CDB_TAG_WIDTH-1:0] out_tag_q;
    logic [IDX_W-1:0]         out_idx_q;
    logic [IDX_W-1:0]         rr_q;

    // Lowest-index free station; alloc_idx stays 0 when none is free.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(RS_COUNT) - 1; i >= 0; i--) begin
            if (free[i]) begin
                any_free  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign accept_cmd                  = bus.command_update_en && any_free && !flush;
    assign bus.command_update_accepted = accept_cmd;
    assign bus.command_result_cdb_tag  = CDB_TAG_WIDTH'(CDB_TAG_OFFSET) +
                                         CDB_TAG_WIDTH'(alloc_idx);

    // Scan READY stations starting at rr_q, wrapping around.
    always_comb begin
        int idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = 0;
        for (int k = 0; k < int'(RS_COUNT); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(RS_COUNT)) idx = idx - int'(RS_COUNT);
            if (!hit && ready[idx]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(idx);
            end
        end
    end

    assign out_fire = out_valid_q && bus.cdb_out_accepted;
    // Reload is allowed on the accept edge, giving one result per cycle.
    assign load     = hit && (!out_valid_q || bus.cdb_out_accepted) && !flush;

    for (genvar i = 0; i < int'(RS_COUNT); i++) begin : g_slot
        alu_rs_slot #(
            .DATA_WIDTH    (DATA_WIDTH),
            .CDB_TAG_WIDTH (CDB_TAG_WIDTH),
            .OP_WIDTH      (OP_WIDTH)
        ) u_slot (
            .clk              (clk),
            .rst_n            (rst_n),
            .flush            (flush),
            .dispatch         (accept_cmd && (alloc_idx == IDX_W'(i))),
            .dispatch_op      (bus.command_op),
            .dispatch_a       (bus.operand_a_data),
            .dispatch_a_valid (bus.operand_a_data_is_valid),
            .dispatch_b       (bus.operand_b_data),
            .dispatch_b_valid (bus.operand_b_data_is_valid),
            .cdb_in_valid     (bus.cdb_in_valid),
            .cdb_in_tag       (bus.cdb_in_tag),
            .cdb_in_data      (bus.cdb_in_data),
            .issue            (load && (hit_idx == IDX_W'(i))),
            .retire           (out_fire && (out_idx_q == IDX_W'(i))),
            .state            (state[i]),
            .result           (result[i])
        );
        assign free[i]  = (state[i] == StFree);
        assign ready[i] = (state[i] == StReady);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_idx_q   <= '0;
            rr_q        <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            rr_q        <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result[hit_idx];
            out_tag_q   <= CDB_TAG_WIDTH'(CDB_TAG_OFFSET) + CDB_TAG_WIDTH'(hit_idx);
            out_idx_q   <= hit_idx;
            rr_q        <= (hit_idx == IDX_W'(RS_COUNT - 1)) ? '0 : hit_idx + IDX_W'(1);
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.cdb_out_request = out_valid_q;
    assign bus.cdb_out_data    = out_data_q;
    assign bus.cdb_out_tag     = out_tag_q;

    always_comb begin
        bus.busy_count = '0;
        for (int i = 0; i < int'(RS_COUNT); i++) begin
            if (!free[i]) bus.busy_count = bus.busy_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_execution_cluster.sv
module tb_alu_execution_cluster;
    import alu_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned RS = 6;
    localparam int unsigned OW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    alu_execution_cluster_if #(
        .DATA_WIDTH    (DW),
        .CDB_TAG_WIDTH (TW),
        .RS_COUNT      (RS),
        .OP_WIDTH      (OW)
    ) bus ();

    alu_execution_cluster #(
        .DATA_WIDTH     (DW),
        .CDB_TAG_WIDTH  (TW),
        .RS_COUNT       (RS),
        .CDB_TAG_OFFSET (0),
        .OP_WIDTH       (OW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // A transfer happens at the next rising edge when request and accept are
    // both high; checked on the falling edge before it.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && bus.cdb_out_request && bus.cdb_out_accepted) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_tag", {28'd0, bus.cdb_out_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_tag", {28'd0, bus.cdb_out_tag}, {28'd0, e.tag});
                    check("sb_data", {28'd0, bus.cdb_out_data}, {28'd0, e.data});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.command_update_en       = 1'b0;
        bus.command_op              = '0;
        bus.operand_a_data          = '0;
        bus.operand_b_data          = '0;
        bus.operand_a_data_is_valid = 1'b0;
        bus.operand_b_data_is_valid = 1'b0;
        bus.cdb_in_valid            = 1'b0;
        bus.cdb_in_tag              = '0;
        bus.cdb_in_data             = '0;
    endtask

    task automatic dispatch(input logic [1:0] op, input logic [3:0] a, input logic av,
                            input logic [3:0] b, input logic bv, input logic exp_acc,
                            input logic [3:0] exp_tag, input string name);
        bus.command_update_en       = 1'b1;
        bus.command_op              = op;
        bus.operand_a_data          = a;
        bus.operand_a_data_is_valid = av;
        bus.operand_b_data          = b;
        bus.operand_b_data_is_valid = bv;
        #1;
        check({name, "_acc"}, {31'd0, bus.command_update_accepted}, {31'd0, exp_acc});
        check({name, "_tag"}, {28'd0, bus.command_result_cdb_tag}, {28'd0, exp_tag});
        @(posedge clk);
        #1;
        bus.command_update_en = 1'b0;
    endtask

    task automatic drain(input int max, output int cycles);
        cycles = 0;
        while (sb_q.size() != 0 && cycles < max) begin
            @(posedge clk);
            cycles++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bus.cdb_out_accepted = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, bus.cdb_out_request}, 0);
        check("rst_data", {28'd0, bus.cdb_out_data}, 0);
        check("rst_tag", {28'd0, bus.cdb_out_tag}, 0);
        check("rst_busy", {29'd0, bus.busy_count}, 0);
        check("rst_acc", {31'd0, bus.command_update_accepted}, 0);
        rst_n = 1'b1;
        tick();

        // ADD 3+4, two-cycle latency
        bus.cdb_out_accepted = 1'b1;
        expect_result(4'd0, 4'd7);
        dispatch(OpAdd, 4'd3, 1'b1, 4'd4, 1'b1, 1'b1, 4'd0, "t1");
        check("t1_req_e0", {31'd0, bus.cdb_out_request}, 0);
        tick();
        check("t1_req_e1", {31'd0, bus.cdb_out_request}, 1);
        tick();
        check("t1_busy", {29'd0, bus.busy_count}, 0);
        check("t1_req_done", {31'd0, bus.cdb_out_request}, 0);

        // SUB with a pending on tag 9 woken two cycles later: 1-2 wraps to F
        expect_result(4'd0, 4'hF);
        dispatch(OpSub, 4'd9, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, "t2");
        tick();
        bus.cdb_in_valid = 1'b1;
        bus.cdb_in_tag   = 4'd9;
        bus.cdb_in_data  = 4'd1;
        tick();
        bus.cdb_in_valid = 1'b0;
        check("t2_req_ew", {31'd0, bus.cdb_out_request}, 0);
        tick();
        check("t2_req_ew1", {31'd0, bus.cdb_out_request}, 1);
        drain(8, cyc);

        // Same-cycle bypass: a pending on tag 5 while tag 5 broadcasts 6; 6^1=7
        expect_result(4'd0, 4'd7);
        bus.cdb_in_valid = 1'b1;
        bus.cdb_in_tag   = 4'd5;
        bus.cdb_in_data  = 4'd6;
        dispatch(OpXor, 4'd5, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, "t3");
        bus.cdb_in_valid = 1'b0;
        check("t3_req_e0", {31'd0, bus.cdb_out_request}, 0);
        tick();
        check("t3_req_e1", {31'd0, bus.cdb_out_request}, 1);
        drain(8, cyc);

        // Fill all stations with the CDB withheld
        bus.cdb_out_accepted = 1'b0;
        do_flush();
        for (int i = 0; i < int'(RS); i++) begin
            expect_result(4'(i), 4'(i + 1));
            dispatch(OpAdd, 4'(i), 1'b1, 4'd1, 1'b1, 1'b1, 4'(i), $sformatf("t4_d%0d", i));
        end
        dispatch(OpAdd, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, "t4_full");
        check("t4_busy", {29'd0, bus.busy_count}, RS);
        check("t4_req", {31'd0, bus.cdb_out_request}, 1);
        tick();
        tick();
        check("t4_hold_tag", {28'd0, bus.cdb_out_tag}, 0);
        check("t4_hold_data", {28'd0, bus.cdb_out_data}, 1);
        bus.cdb_out_accepted = 1'b1;
        drain(20, cyc);
        check("t4_cycles", cyc, RS);
        check("t4_busy_end", {29'd0, bus.busy_count}, 0);

        // Round-robin: park rr_ptr at 3, then make stations 2 and 4 READY together
        bus.cdb_out_accepted = 1'b0;
        do_flush();
        dispatch(OpAdd, 4'd10, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, "t5_d0");
        dispatch(OpAdd, 4'd10, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, "t5_d1");
        expect_result(4'd2, 4'd2);
        dispatch(OpAdd, 4'd1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2, "t5_d2");
        dispatch(OpAdd, 4'd10, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, "t5_d3");
        check("t5_req", {31'd0, bus.cdb_out_request}, 1);
        bus.cdb_out_accepted = 1'b1;
        tick();
        bus.cdb_out_accepted = 1'b0;
        check("t5_busy", {29'd0, bus.busy_count}, 3);
        dispatch(OpAdd, 4'd11, 1'b0, 4'd1, 1'b1, 1'b1, 4'd2, "t5_d2b");
        dispatch(OpSub, 4'd11, 1'b0, 4'd2, 1'b1, 1'b1, 4'd4, "t5_d4");
        expect_result(4'd4, 4'd3);
        expect_result(4'd2, 4'd6);
        bus.cdb_in_valid     = 1'b1;
        bus.cdb_in_tag       = 4'd11;
        bus.cdb_in_data      = 4'd5;
        bus.cdb_out_accepted = 1'b1;
        tick();
        bus.cdb_in_valid = 1'b0;
        drain(10, cyc);

        // Flush with three busy and the request high
        bus.cdb_out_accepted = 1'b0;
        do_flush();
        dispatch(OpAdd, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd0, "t6_d0");
        dispatch(OpAdd, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd1, "t6_d1");
        dispatch(OpAdd, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, "t6_d2");
        check("t6_req", {31'd0, bus.cdb_out_request}, 1);
        check("t6_busy", {29'd0, bus.busy_count}, 3);
        flush                       = 1'b1;
        bus.command_update_en       = 1'b1;
        bus.operand_a_data_is_valid = 1'b1;
        bus.operand_b_data_is_valid = 1'b1;
        #1;
        check("t6_acc_flush", {31'd0, bus.command_update_accepted}, 0);
        tick();
        flush                 = 1'b0;
        bus.command_update_en = 1'b0;
        check("t6_req_flushed", {31'd0, bus.cdb_out_request}, 0);
        check("t6_busy_flushed", {29'd0, bus.busy_count}, 0);
        expect_result(4'd0, 4'd8);
        dispatch(OpAnd, 4'b1100, 1'b1, 4'b1010, 1'b1, 1'b1, 4'd0, "t6_after");
        bus.cdb_out_accepted = 1'b1;
        drain(10, cyc);

        // Asynchronous reset mid-operation
        bus.cdb_out_accepted = 1'b0;
        dispatch(OpAdd, 4'd1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd0, "t7");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_req", {31'd0, bus.cdb_out_request}, 0);
        check("t7_data", {28'd0, bus.cdb_out_data}, 0);
        check("t7_busy", {29'd0, bus.busy_count}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        check("sb_left", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_execution_cluster.md
# alu_execution_cluster

Parametrised successor of the ALU execution unit: a pool of RS_COUNT ALU reservation stations behind one command port, now with opcodes, operand tag-wait with CDB snooping (including same-cycle dispatch bypass), an internal round-robin issue pointer, a registered CDB output stage and flush. Sits between the frontend dispatch logic and the common data bus. Stalls the frontend by holding command_update_accepted low when every station is occupied.

## Interface
- DATA_WIDTH, 4, bitwidth of a data word
- CDB_TAG_WIDTH, 4, CDB tag bitwidth; CDB_TAG_WIDTH <= DATA_WIDTH
- RS_COUNT, 6, number of reservation stations; >= 2
- CDB_TAG_OFFSET, 0, tag of station 0; CDB_TAG_OFFSET+RS_COUNT-1 < 2^CDB_TAG_WIDTH
- OP_WIDTH, 2, opcode width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all in-flight work
- cdb_in_valid / cdb_in_tag / cdb_in_data  in  1 / CDB_TAG_WIDTH / DATA_WIDTH  CDB snoop
- cdb_out_request  out  1  output register valid
- cdb_out_data / cdb_out_tag  out  DATA_WIDTH / CDB_TAG_WIDTH  registered result, tag
- cdb_out_accepted  in  1  CDB grant for current output
- command_update_en  in  1  dispatch request
- command_op  in  OP_WIDTH  0 ADD, 1 SUB, 2 AND, 3 XOR
- operand_a_data, operand_b_data  in  DATA_WIDTH  value, or producer tag in low CDB_TAG_WIDTH bits when not valid
- operand_a_data_is_valid, operand_b_data_is_valid  in  1
- command_update_accepted  out  1  dispatch taken this cycle
- command_result_cdb_tag  out  CDB_TAG_WIDTH  tag assigned to the dispatched command
- busy_count  out  $clog2(RS_COUNT+1)  number of non-FREE stations

## Operation
- Station states: FREE -> WAIT (an operand pending) or READY (both valid) on dispatch; WAIT -> READY once both captured; READY -> ISSUED when loaded into output register; ISSUED -> FREE on the edge where cdb_out_request && cdb_out_accepted.
- Tag stays reserved until broadcast completes; no tag reuse while its result sits in the output register.
- Dispatch: lowest-index FREE station. command_update_accepted = command_update_en && any FREE && !flush. command_result_cdb_tag = CDB_TAG_OFFSET + index; equals CDB_TAG_OFFSET when no station is free.
- Snoop: every pending operand whose tag equals cdb_in_tag with cdb_in_valid captures cdb_in_data. Same-cycle bypass: a dispatched pending operand matching the current CDB is stored as valid. Both operands may match one broadcast.
- Results are mod 2^DATA_WIDTH; SUB = a - b wraps.
- Issue: rr_ptr register; scan READY stations from rr_ptr upward, wrapping; first hit loads the output register when it is empty or being accepted this cycle; rr_ptr <= hit+1 mod RS_COUNT. Without a hit, rr_ptr holds.
- Output register holds data/tag stable while request is high and not accepted.
- flush (priority over everything but reset): all stations FREE, output register invalid, rr_ptr 0; dispatch ignored.

## Timing
- Reset: cdb_out_request 0, cdb_out_data 0, cdb_out_tag 0, busy_count 0, rr_ptr 0, all stations FREE; command_update_accepted 0 while command_update_en 0.
- Ready-operand command dispatched at edge E0 -> READY after E0 -> loaded at E1 -> cdb_out_request high after E1 (2-cycle latency).
- Operand woken by CDB at edge Ew -> earliest request after Ew+1.
- Accept-and-reload in one edge: back-to-back results, one per cycle.
- A station freed at edge E is dispatchable after E, never in the freeing cycle.
- Full: all stations non-FREE -> accepted 0, busy_count = RS_COUNT.
- Reset mid-operation discards everything immediately (asynchronous).

## Structure
- Package alu_pkg: opcode constants, station state encoding (FREE, WAIT, READY, ISSUED).
- Sub-module alu_rs_slot: one station (state, operand/tag storage, snoop, ALU compute, result).
- Top: free-station priority select, one-hot to tag, rr issue pointer, output register, busy count. Existing priority_arbiter and onehot_to_binary are reusable.

## Test plan
- Dispatch ADD 3+4, both valid -> accepted, tag 0; request high 2 cycles later with data 7, tag 0; accept -> busy_count 0.
- Dispatch SUB with a pending on tag 9, b=2; CDB tag 9 data 1 two cycles later -> result 0xF (wrap), tag 0.
- Dispatch with a pending on tag 5 while CDB broadcasts tag 5 data 6 same cycle, b=1 XOR -> result 7, no stall.
- Fill 6 stations with cdb_out_accepted low -> 7th dispatch rejected, busy_count 6, data/tag stable; release accept -> tags 0..5 each once, one per cycle.
- Stations 2 and 4 READY, rr_ptr 3 -> tag 4 issued first, then 2.
- Flush with 3 busy and request high -> next cycle request 0, busy_count 0, dispatch gets tag 0.
